// File: rtl/fwd_bypass_net.sv
// Operand-forwarding network: tracks in-flight register writes per pipeline stage,
// captures produced results and resolves decode read ports to the youngest producer.
module fwd_bypass_net #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 2,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     iss_valid,
  input  logic                     iss_wen,
  input  logic [RA_W-1:0]          iss_waddr,
  input  logic [DEPTH-1:0]         prod_en,
  input  logic [DEPTH*DATA_W-1:0]  prod_data,
  input  logic [NUM_RD*RA_W-1:0]   rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
  output logic [NUM_RD-1:0]        stall_vec,
  output logic                     stall
);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_ready;
  logic [RA_W-1:0]   ent_waddr [DEPTH];
  logic [DATA_W-1:0] ent_data  [DEPTH];

  // Entry contents after this cycle's capture; these are what shift or stay.
  logic [DEPTH-1:0]  cap_ready;
  logic [DATA_W-1:0] cap_data [DEPTH];
  logic              load_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cap_ready[i] = ent_ready[i] | (prod_en[i] & ent_valid[i]);
      cap_data[i]  = (prod_en[i] & ent_valid[i]) ? prod_data[i*DATA_W +: DATA_W] : ent_data[i];
    end
  end

  assign load_valid = iss_valid & iss_wen & (iss_waddr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_ready[i] <= 1'b0;
        ent_waddr[i] <= '0;
        ent_data[i]  <= '0;
      end
    end else if (hold) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_ready[i] <= cap_ready[i];
        ent_data[i]  <= cap_data[i];
      end
    end else begin
      ent_valid[0] <= load_valid;
      ent_ready[0] <= 1'b0;
      ent_waddr[0] <= load_valid ? iss_waddr : '0;
      ent_data[0]  <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_ready[i] <= cap_ready[i-1];
        ent_waddr[i] <= ent_waddr[i-1];
        ent_data[i]  <= cap_data[i-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest match wins, ready or not.
  logic              m_hit;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [SEL_W-1:0]  m_sel;

  always_comb begin
    fwd_data  = rf_data;
    fwd_sel   = '0;
    stall_vec = '0;
    m_hit     = 1'b0;
    m_ready   = 1'b0;
    m_data    = '0;
    m_sel     = '0;
    for (int c = 0; c < NUM_RD; c++) begin
      m_hit   = 1'b0;
      m_ready = 1'b0;
      m_data  = '0;
      m_sel   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (ent_valid[i] && (ent_waddr[i] == rd_addr[c*RA_W +: RA_W])) begin
          m_hit   = 1'b1;
          m_ready = cap_ready[i];
          m_data  = cap_data[i];
          m_sel   = SEL_W'(i + 1);
        end
      end
      if (m_hit && (rd_addr[c*RA_W +: RA_W] != '0)) begin
        if (m_ready) begin
          fwd_data[c*DATA_W +: DATA_W] = m_data;
          fwd_sel[c*SEL_W +: SEL_W]    = m_sel;
        end else begin
          stall_vec[c] = 1'b1;
        end
      end
    end
  end

  assign stall = |stall_vec;

endmodule
